// File: rtl/main_mem_responder.sv
// Fixed-latency main-memory responder: one read/write in flight, answered after LATENCY cycles.
// Optional MEM_PARITY_EN adds a stored even-parity bit per word and a read parity-error pulse.
module main_mem_responder #(
    parameter int DEPTH    = 4096,
    parameter int ADDR_LSB = 3,
    parameter int LATENCY  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd_en,
    input  logic        mem_wr_en,
    input  logic [31:0] mem_addr,
    input  logic [63:0] mem_wr_data,
    output logic [63:0] mem_rd_data,
    output logic        mem_rd_valid,
    output logic        mem_wr_ack,
    output logic        mem_busy,
    output logic        mem_rd_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic             wr;
        logic [IDX_W-1:0] idx;
        logic [63:0]      wdata;
    } req_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    req_t             req_q;
    logic             capture;
    logic             do_op;

    logic [63:0]      mem [DEPTH];

    logic [63:0]      rd_data_q;
    logic             rd_valid_q;
    logic             wr_ack_q;

    // Only the index slice of the address matters; the rest aliases.
    logic             unused_addr;
    assign unused_addr = ^mem_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        do_op     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_rd_en || mem_wr_en) begin
                    capture   = 1'b1;
                    cnt_nxt   = CNT_W'(LATENCY - 1);
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    do_op     = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request is frozen at acceptance so later input changes cannot leak in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q <= '0;
        end else if (capture) begin
            req_q.wr    <= mem_wr_en;
            req_q.idx   <= mem_addr[ADDR_LSB +: IDX_W];
            req_q.wdata <= mem_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_ack_q   <= 1'b0;
        end else begin
            rd_valid_q <= do_op && !req_q.wr;
            wr_ack_q   <= do_op && req_q.wr;
            if (do_op && !req_q.wr) begin
                rd_data_q <= mem[req_q.idx];
            end
        end
    end

    // Backing store is not reset; a reset during WAIT leaves state IDLE so do_op stays low.
    always_ff @(posedge clk) begin
        if (do_op && req_q.wr) begin
            mem[req_q.idx] <= req_q.wdata;
        end
    end

`ifdef MEM_PARITY_EN
    logic par [DEPTH];
    logic rd_err_q;

    always_ff @(posedge clk) begin
        if (do_op && req_q.wr) begin
            par[req_q.idx] <= ^req_q.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_err_q <= 1'b0;
        end else begin
            rd_err_q <= do_op && !req_q.wr && ((^mem[req_q.idx]) != par[req_q.idx]);
        end
    end

    assign mem_rd_err = rd_err_q;
`else
    assign mem_rd_err = 1'b0;
`endif

    assign mem_rd_data  = rd_data_q;
    assign mem_rd_valid = rd_valid_q;
    assign mem_wr_ack   = wr_ack_q;
    assign mem_busy     = (state == ST_WAIT);

endmodule
